sin_rom_arb: RTL and testbench
==============================

Name: sin_rom_arb

Overview:
- Two-port round-robin arbiter that shares one synchronous sine lookup ROM between two requesters, e.g. the I and Q phase paths of a DDFS or two independent oscillators.
- Sits between the requesters' phase-to-address logic and the ROM instance. It drives the ROM address and routes each registered ROM word back to the requester that issued it.
- Full throughput: one ROM read per cycle, fixed request-to-response latency.

Parameters:
- DATA_WIDTH, 16, width of a ROM word (signed sine sample).
- ADDR_WIDTH, 9, width of the ROM address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an address to look up.
- req0_addr  in  ADDR_WIDTH  requester 0 lookup address.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid  in  1  requester 1 has an address to look up.
- req1_addr  in  ADDR_WIDTH  requester 1 lookup address.
- req1_ready  out  1  requester 1 request accepted this cycle.
- rom_addr  out  ADDR_WIDTH  address to ROM; the ROM registers its data on the next clk edge.
- rom_data  in  DATA_WIDTH  ROM output, valid 1 cycle after rom_addr.
- rsp0_valid  out  1  one-cycle pulse: rsp0_data updated.
- rsp0_data  out  DATA_WIDTH  last sample returned to requester 0, held between pulses.
- rsp1_valid  out  1  one-cycle pulse: rsp1_data updated.
- rsp1_data  out  DATA_WIDTH  last sample returned to requester 1, held between pulses.

Behaviour:
- Reset values, applied asynchronously on reset:
  - last_grant = 1, so requester 0 wins the first tie.
  - Both in-flight tag stages cleared.
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_data = rsp1_data = 0.
- Grant is combinational in cycle N:
  - only req0_valid high: grant 0.
  - only req1_valid high: grant 1.
  - both high: grant the requester that is not last_grant.
  - neither high: no grant.
- Ready and address:
  - reqX_ready = 1 only when X is granted. Ready is never asserted without valid.
  - At most one ready is high per cycle.
  - A request is accepted when valid and ready are both high.
- rom_addr = winner's address in cycle N; 0 when there is no grant.
- last_grant updates at the clk edge ending any cycle with a grant. It is unchanged in idle cycles.
- Pipeline:
  - Stage 1 (cycle N+1): tag {valid, id} registered at the end of cycle N; rom_data holds that word.
  - Stage 2 (cycle N+2): if the stage-1 tag is valid, rsp<id>_data <= rom_data and rsp<id>_valid <= 1; the other response valid <= 0.
  - Latency: request accepted in cycle N gives its response pulse in cycle N+2.
- Throughput: 1 grant per cycle. With both requesters continuously valid, grants strictly alternate.
- Response data registers change only on their own valid pulse. They hold their value indefinitely otherwise.
- No back-pressure on responses: requesters must always accept rsp pulses.
- A requester may change its address or drop valid after any cycle, accepted or not. Unaccepted requests leave no state.
- Reset mid-operation:
  - In-flight tags are discarded; no response pulse is ever emitted for requests accepted before reset.
  - Held response data is cleared to 0.
  - Arbitration restarts with requester 0 priority.
- Simultaneous events: a new grant and a response for the other (or the same) requester in the same cycle are independent. There are no stalls.

Test Plan:
- After reset, only req0_valid=1, req0_addr=0x040 for one cycle -> req0_ready=1 and rom_addr=0x040 that cycle. Two cycles later rsp0_valid=1 for exactly one cycle with rsp0_data=ROM[0x040]. rsp1_valid stays 0 and rsp1_data stays 0.
- First cycle after reset, both valid, addr0=0x010, addr1=0x020 -> req0 granted (rom_addr=0x010). Holding both valid, next cycle req1 is granted (rom_addr=0x020). Responses: rsp0 at N+2, rsp1 at N+3 with matching ROM words.
- Both valid for 8 consecutive cycles, each side incrementing its address -> grants alternate 0,1,0,1,... Each requester receives 4 responses in order with the correct words, and exactly one response pulse per cycle from N+2 to N+9.
- Only req1 valid for 5 back-to-back cycles, addresses 0x1FB..0x1FF -> req1_ready=1 every cycle. Five consecutive rsp1 pulses with ROM[0x1FB..0x1FF]. rsp0_data unchanged throughout.
- Accept req0 addr 0x0AA at cycle N, then assert reset during cycle N+1 -> no rsp0_valid pulse follows. rsp0_data=0 after reset. The next tie is won by req0.
- Req0 response at 0x080 followed by 10 idle cycles -> rsp0_data holds ROM[0x080] for all 10 cycles with rsp0_valid=0. rom_addr=0 and both readys are 0 while idle.

Source files
------------

// File: rtl/sin_rom_arb.sv
// Two-requester round-robin arbiter sharing one synchronous sine ROM; one read per cycle.
// Grant is combinational, response pulses 2 cycles after acceptance, no response backpressure.
module sin_rom_arb #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data
);

  logic w_grant_vld;
  logic w_grant_id;
  logic r_last_grant;
  logic r_tag_vld;
  logic r_tag_id;

  // On a tie the requester that did not win last time takes the slot.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = ~r_last_grant;
    end else if (req0_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b0;
    end else if (req1_valid) begin
      w_grant_vld = 1'b1;
      w_grant_id  = 1'b1;
    end
  end

  assign req0_ready = w_grant_vld && !w_grant_id;
  assign req1_ready = w_grant_vld &&  w_grant_id;
  assign rom_addr   = !w_grant_vld ? '0 : (w_grant_id ? req1_addr : req0_addr);

  // Tag travels alongside the ROM's own address-to-data register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_tag_vld    <= 1'b0;
      r_tag_id     <= 1'b0;
    end else begin
      r_tag_vld <= w_grant_vld;
      r_tag_id  <= w_grant_id;
      if (w_grant_vld) begin
        r_last_grant <= w_grant_id;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= r_tag_vld && !r_tag_id;
      rsp1_valid <= r_tag_vld &&  r_tag_id;
      if (r_tag_vld && !r_tag_id) begin
        rsp0_data <= rom_data;
      end
      if (r_tag_vld && r_tag_id) begin
        rsp1_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sin_rom_arb.sv
// Randomized and directed bench for sin_rom_arb against a queue-based transaction model.
module tb_sin_rom_arb;

  localparam int DW = 16;
  localparam int AW = 9;

  logic          clk;
  logic          reset;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic          req1_ready;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_data;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_data;

  sin_rom_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM with random contents: data appears one edge after the address.
  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    int          due;
    bit          id;
    logic [AW-1:0] addr;
  } pend_t;

  pend_t         pend[$];
  bit            m_last;
  logic [DW-1:0] m_data0;
  logic [DW-1:0] m_data1;
  int            cyc;
  int            n_checks;
  int            n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One bus cycle: drive, predict, compare mid-cycle, then record the accepted request.
  task automatic cycle(input bit v0, input logic [AW-1:0] a0, input bit v1, input logic [AW-1:0] a1);
    bit            gv;
    bit            gid;
    logic [AW-1:0] ga;
    bit            p0;
    bit            p1;
    pend_t         p;
    req0_valid = v0;
    req0_addr  = a0;
    req1_valid = v1;
    req1_addr  = a1;
    gv  = v0 || v1;
    gid = (v0 && v1) ? !m_last : v1;
    ga  = !gv ? '0 : (gid ? a1 : a0);
    p0 = 1'b0;
    p1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      if (p.id) begin
        p1 = 1'b1;
        m_data1 = rom_mem[p.addr];
      end else begin
        p0 = 1'b1;
        m_data0 = rom_mem[p.addr];
      end
    end
    @(negedge clk);
    chk("req0_ready", 32'(req0_ready), 32'(gv && !gid));
    chk("req1_ready", 32'(req1_ready), 32'(gv && gid));
    chk("rom_addr",   32'(rom_addr),   32'(ga));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(p0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(p1));
    chk("rsp0_data",  32'(rsp0_data),  32'(m_data0));
    chk("rsp1_data",  32'(rsp1_data),  32'(m_data1));
    if (gv) begin
      pend.push_back('{due: cyc + 2, id: gid, addr: ga});
      m_last = gid;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset      = 1'b1;
    #1;
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_data",  32'(rsp0_data),  32'd0);
    chk("rst_rsp1_data",  32'(rsp1_data),  32'd0);
    pend.delete();
    m_last  = 1'b1;
    m_data0 = '0;
    m_data1 = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr  = '0;
    req1_addr  = '0;
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'($urandom);
    @(posedge clk);
    #1;
    do_reset();

    // Lone req0, then idle until its pulse has passed.
    cycle(1, 9'h040, 0, 9'h000);
    for (int i = 0; i < 3; i++) cycle(0, 9'h000, 0, 9'h000);

    // Tie right after reset goes to req0, then req1.
    do_reset();
    cycle(1, 9'h010, 1, 9'h020);
    cycle(1, 9'h010, 1, 9'h020);
    for (int i = 0; i < 3; i++) cycle(0, 9'h000, 0, 9'h000);

    // Sustained contention alternates with incrementing addresses.
    for (int i = 0; i < 8; i++) cycle(1, 9'(9'h100 + i), 1, 9'(9'h180 + i));
    for (int i = 0; i < 3; i++) cycle(0, 9'h000, 0, 9'h000);

    // req1 alone up to the top of the address range.
    for (int i = 0; i < 5; i++) cycle(0, 9'h000, 1, 9'(9'h1FB + i));
    for (int i = 0; i < 3; i++) cycle(0, 9'h000, 0, 9'h000);

    // Reset while a req0 response is still in flight, then check tie priority.
    cycle(1, 9'h0AA, 0, 9'h000);
    do_reset();
    cycle(0, 9'h000, 0, 9'h000);
    cycle(1, 9'h011, 1, 9'h022);
    cycle(0, 9'h000, 0, 9'h000);
    cycle(0, 9'h000, 0, 9'h000);

    // Held response data across a long idle stretch.
    cycle(1, 9'h080, 0, 9'h000);
    for (int i = 0; i < 12; i++) cycle(0, 9'h000, 0, 9'h000);

    // Random traffic with occasional mid-flight resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      cycle(bit'($urandom_range(0, 3) != 0), AW'($urandom),
            bit'($urandom_range(0, 3) != 0), AW'($urandom));
    end
    for (int i = 0; i < 3; i++) cycle(0, 9'h000, 0, 9'h000);
    chk("drain_empty", 32'(pend.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
